// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronises and filters clk_kb/data_kb, deframes 11-bit
// frames, folds E0/F0 prefixes into flags and queues scan codes in a show-ahead FIFO.
module ps2_scancode_receiver #(
  parameter int DEPTH          = 4,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DECODE_PREFIX  = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       clk_kb,
  input  logic       data_kb,
  input  logic       iRead,
  output logic [7:0] oData,
  output logic       oExtended,
  output logic       oBreak,
  output logic       oEmpty,
  output logic       oFull,
  output logic       oParity_Error,
  output logic       oFrame_Error,
  output logic       oTimeout,
  output logic       oOverflow,
  output logic [1:0] oDbg_State
);

  localparam int AW  = $clog2(DEPTH);
  localparam int FCW = $clog2(FILTER_LEN);
  localparam int TCW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  state_e         state_q, state_d;
  logic           clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic           data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic           clk_filt_q, clk_filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           accept_q, accept_d;
  logic           par_err_q, par_err_d;
  logic           frame_err_q, frame_err_d;
  logic           timeout_q, timeout_d;
  logic           overflow_q, overflow_d;
  logic           ext_q, ext_d, brk_q, brk_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [9:0]     mem_q [DEPTH];
  logic [9:0]     mem_d [DEPTH];

  logic fall, timeout_hit;
  logic is_e0, is_f0, push, pop, wr_en, empty, full;
  logic [9:0] head;

  // Input path: 2-FF synchronisers, then a run-length filter on the clock line.
  always_comb begin
    clk_s1_d   = clk_kb;
    clk_s2_d   = clk_s1_q;
    data_s1_d  = data_kb;
    data_s2_d  = data_s1_q;
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != clk_filt_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) clk_filt_d = clk_s2_q;
      else                                   filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall = clk_filt_q & ~clk_filt_d;
  end

  always_comb begin
    to_cnt_d    = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + 1'b1;
    timeout_hit = (state_q != S_IDLE) && !fall && (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1));
  end

  // FSM process 1: state register.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM process 2: next state.
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = S_IDLE;
    end else if (fall) begin
      case (state_q)
        S_IDLE:   if (!data_s2_q) state_d = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM process 3: frame datapath and error/accept pulses.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    accept_d    = 1'b0;
    par_err_d   = 1'b0;
    frame_err_d = 1'b0;
    timeout_d   = timeout_hit;
    if (fall) begin
      case (state_q)
        S_IDLE:   bit_cnt_d = 3'd0;
        S_DATA: begin
          shift_d   = {data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        S_PARITY: par_d = data_s2_q;
        S_STOP: begin
          if (!data_s2_q)                    frame_err_d = 1'b1;
          else if (^{shift_q, par_q} == 1'b0) par_err_d  = 1'b1;
          else                                accept_d   = 1'b1;
        end
        default: bit_cnt_d = 3'd0;
      endcase
    end
  end

  // Prefix folding and FIFO; shift_q still holds the accepted byte during accept_q.
  always_comb begin
    is_e0 = (DECODE_PREFIX != 0) && (shift_q == 8'hE0);
    is_f0 = (DECODE_PREFIX != 0) && (shift_q == 8'hF0);
    push  = accept_q && !is_e0 && !is_f0;
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop   = iRead && !empty;
    wr_en = push && (!full || pop);
    overflow_d = push && full && !pop;
    ext_d = ext_q;
    brk_d = brk_q;
    if (accept_q) begin
      if (is_e0)      ext_d = 1'b1;
      else if (is_f0) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q[AW-1:0]] = {ext_q, brk_q, shift_q};
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    head     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      data_s1_q   <= 1'b1;
      data_s2_q   <= 1'b1;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
      to_cnt_q    <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      accept_q    <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 10'd0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      data_s1_q   <= data_s1_d;
      data_s2_q   <= data_s2_d;
      clk_filt_q  <= clk_filt_d;
      filt_cnt_q  <= filt_cnt_d;
      to_cnt_q    <= to_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      accept_q    <= accept_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      overflow_q  <= overflow_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

  // Head fields read as zero while empty so stale entries never leak out.
  assign oData         = empty ? 8'd0 : head[7:0];
  assign oExtended     = empty ? 1'b0 : head[9];
  assign oBreak        = empty ? 1'b0 : head[8];
  assign oEmpty        = empty;
  assign oFull         = full;
  assign oParity_Error = par_err_q;
  assign oFrame_Error  = frame_err_q;
  assign oTimeout      = timeout_q;
  assign oOverflow     = overflow_q;
  assign oDbg_State    = state_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Scoreboard bench for ps2_scancode_receiver: directed PS/2 frames, expected
// {ext,brk,code} entries queued at issue time, popped by an independent reader.
module tb_ps2_scancode_receiver;

  logic       Clock, Reset, clk_kb, data_kb, iRead;
  logic [7:0] oData;
  logic       oExtended, oBreak, oEmpty, oFull;
  logic       oParity_Error, oFrame_Error, oTimeout, oOverflow;
  logic [1:0] oDbg_State;

  logic [9:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0;
  logic auto_read = 1'b0;

  ps2_scancode_receiver #(
    .DEPTH(4), .FILTER_LEN(4), .TIMEOUT_CYCLES(2000), .DECODE_PREFIX(1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .clk_kb(clk_kb), .data_kb(data_kb), .iRead(iRead),
    .oData(oData), .oExtended(oExtended), .oBreak(oBreak), .oEmpty(oEmpty), .oFull(oFull),
    .oParity_Error(oParity_Error), .oFrame_Error(oFrame_Error), .oTimeout(oTimeout),
    .oOverflow(oOverflow), .oDbg_State(oDbg_State)
  );

  // Clock / reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    repeat (80000) @(posedge Clock);
    $display("FAIL watchdog: actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Driver tasks: one PS/2 bit is 40 cycles high (data changes mid-high) then 40 low.
  task automatic ps2_bit(input logic b);
    repeat (20) @(negedge Clock);
    data_kb = b;
    repeat (20) @(negedge Clock);
    clk_kb = 1'b0;
    repeat (40) @(negedge Clock);
    clk_kb = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop_b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ par_bad);
    ps2_bit(stop_b);
    repeat (20) @(negedge Clock);
    data_kb = 1'b1;
    repeat (40) @(negedge Clock);
  endtask

  task automatic send_partial(input logic [7:0] b, input int ndata);
    ps2_bit(1'b0);
    for (int i = 0; i < ndata; i++) ps2_bit(b[i]);
    repeat (20) @(negedge Clock);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 600; i++) begin
      @(negedge Clock);
      #1;
      if (exp_q.size() == 0 && oEmpty && !iRead) break;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_empty"}, oEmpty, 1'b1);
  endtask

  // Scoreboard monitor: pops the FIFO whenever it presents data and auto_read is on.
  initial begin
    iRead = 1'b0;
    forever begin
      @(negedge Clock);
      if (iRead) begin
        iRead = 1'b0;
      end else if (auto_read && !Reset && !oEmpty) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_entry: actual=%0h required=none", {oExtended, oBreak, oData});
        end else begin
          chk("fifo_head", {22'd0, oExtended, oBreak, oData}, {22'd0, exp_q.pop_front()});
        end
        iRead = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clock);
      if (oParity_Error) n_par++;
      if (oFrame_Error)  n_frm++;
      if (oTimeout)      n_to++;
      if (oOverflow)     n_ovf++;
    end
  end

  // Directed stimulus
  initial begin
    int p0;
    Reset = 1'b1; clk_kb = 1'b1; data_kb = 1'b1;
    repeat (5) @(negedge Clock);
    chk("rst_empty", oEmpty, 1'b1);
    chk("rst_full", oFull, 1'b0);
    chk("rst_data", oData, 8'h00);
    chk("rst_ext", oExtended, 1'b0);
    chk("rst_brk", oBreak, 1'b0);
    chk("rst_state", oDbg_State, 2'd0);
    chk("rst_pulses", {oParity_Error, oFrame_Error, oTimeout, oOverflow}, 4'b0000);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);

    // Single make code
    auto_read = 1'b1;
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_drain("plain_1c");

    // F0 1C (release), then E0 F0 75 (extended release)
    exp_q.push_back({2'b01, 8'h1C});
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    exp_q.push_back({2'b11, 8'h75});
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    wait_drain("prefix");

    // Bad parity
    p0 = n_par;
    send_frame(8'h1C, 1'b1, 1'b1);
    repeat (20) @(negedge Clock);
    chk("parity_pulses", n_par - p0, 1);
    chk("parity_empty", oEmpty, 1'b1);

    // Stop bit low
    p0 = n_frm;
    send_frame(8'h2A, 1'b0, 1'b0);
    repeat (20) @(negedge Clock);
    chk("frame_pulses", n_frm - p0, 1);
    chk("frame_empty", oEmpty, 1'b1);

    // Partial frame then timeout
    p0 = n_to;
    send_partial(8'h1C, 3);
    chk("partial_state", oDbg_State, 2'd1);
    repeat (2100) @(negedge Clock);
    chk("timeout_pulses", n_to - p0, 1);
    chk("timeout_state", oDbg_State, 2'd0);
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_drain("after_timeout");

    // Fill FIFO without reading, overflow on the 5th code
    auto_read = 1'b0;
    p0 = n_ovf;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back({2'b00, 8'(v)});
      send_frame(8'(v), 1'b0, 1'b1);
      if (v == 3) chk("full_after_3", oFull, 1'b0);
      if (v == 4) chk("full_after_4", oFull, 1'b1);
    end
    chk("overflow_pulses", n_ovf - p0, 1);
    chk("full_after_5", oFull, 1'b1);
    chk("head_while_full", oData, 8'h01);
    auto_read = 1'b1;
    wait_drain("full_drain");
    chk("full_cleared", oFull, 1'b0);

    // Reset in the middle of a frame
    send_partial(8'h55, 4);
    chk("midframe_state", oDbg_State, 2'd1);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    chk("reset_state", oDbg_State, 2'd0);
    chk("reset_empty", oEmpty, 1'b1);
    repeat (10) @(negedge Clock);
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_drain("after_reset");

    chk("total_timeouts", n_to, 1);
    chk("total_overflows", n_ovf, 1);
    chk("total_parity", n_par, 1);
    chk("total_frame", n_frm, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
